// File: rtl/nd_rr_4to1_pkg.sv
// Shared types and helpers for the four-input round-robin merge node.
// Holds the output-channel state encoding and the arbiter pointer helper.
package nd_rr_4to1_pkg;

    localparam int NUM_IN = 4;

    typedef enum logic [1:0] {
        SND_IDLE = 2'd0,
        SND_BUSY = 2'd1,
        SND_WAIT = 2'd2
    } snd_state_e;

    function automatic logic [1:0] rr_inc(input logic [1:0] idx);
        return idx + 2'd1;
    endfunction

endpackage

// File: rtl/ns_msg_fifo.sv
// Circular message store for the merge node: one push and one pop port,
// packed message bus, occupancy count plus full/empty flags.
module ns_msg_fifo #(
    parameter int FSZ = 4,
    parameter int MW  = 28
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_push,
    input  logic [MW-1:0]         i_push_msg,
    input  logic                  i_pop,
    output logic [MW-1:0]         o_head_msg,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [$clog2(FSZ):0]  o_count
);

    localparam int IW = (FSZ > 1) ? $clog2(FSZ) : 1;
    localparam int CW = $clog2(FSZ) + 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(FSZ - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(FSZ);

    logic [MW-1:0] r_mem [FSZ];
    logic [IW-1:0] r_wr_idx;
    logic [IW-1:0] r_rd_idx;
    logic [CW-1:0] r_count;
    logic          w_push_ok;
    logic          w_pop_ok;

    function automatic logic [IW-1:0] idx_next(input logic [IW-1:0] idx);
        return (idx == LAST_IDX) ? '0 : idx + 1'b1;
    endfunction

    assign o_full     = (r_count == FULL_CNT);
    assign o_empty    = (r_count == '0);
    assign o_count    = r_count;
    assign o_head_msg = r_mem[r_rd_idx];
    assign w_push_ok  = i_push && !o_full;
    assign w_pop_ok   = i_pop && !o_empty;

    // Storage carries no reset; only slots behind a valid count are ever read.
    always_ff @(posedge i_clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_idx] <= i_push_msg;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_idx <= '0;
            r_rd_idx <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_idx <= idx_next(r_wr_idx);
            end
            if (w_pop_ok) begin
                r_rd_idx <= idx_next(r_rd_idx);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/nd_rr_4to1.sv
// Four-input round-robin merge node: arbitrates four 4-phase receive channels
// into a message FIFO and drains it through one 4-phase send channel.
module nd_rr_4to1
    import nd_rr_4to1_pkg::*;
#(
    parameter int FSZ = 4,
    parameter int ASZ = 8,
    parameter int DSZ = 8,
    parameter int RSZ = 4
) (
    input  logic                 gch_clk,
    input  logic                 gch_reset,
    output logic                 gch_ready,
    input  logic [3:0]           cfg_en,

    input  logic                 rcv0_req,
    output logic                 rcv0_ack,
    input  logic [ASZ-1:0]       rcv0_src,
    input  logic [ASZ-1:0]       rcv0_dst,
    input  logic [DSZ-1:0]       rcv0_dat,
    input  logic [RSZ-1:0]       rcv0_red,

    input  logic                 rcv1_req,
    output logic                 rcv1_ack,
    input  logic [ASZ-1:0]       rcv1_src,
    input  logic [ASZ-1:0]       rcv1_dst,
    input  logic [DSZ-1:0]       rcv1_dat,
    input  logic [RSZ-1:0]       rcv1_red,

    input  logic                 rcv2_req,
    output logic                 rcv2_ack,
    input  logic [ASZ-1:0]       rcv2_src,
    input  logic [ASZ-1:0]       rcv2_dst,
    input  logic [DSZ-1:0]       rcv2_dat,
    input  logic [RSZ-1:0]       rcv2_red,

    input  logic                 rcv3_req,
    output logic                 rcv3_ack,
    input  logic [ASZ-1:0]       rcv3_src,
    input  logic [ASZ-1:0]       rcv3_dst,
    input  logic [DSZ-1:0]       rcv3_dat,
    input  logic [RSZ-1:0]       rcv3_red,

    output logic                 snd0_req,
    input  logic                 snd0_ack,
    output logic [ASZ-1:0]       snd0_src,
    output logic [ASZ-1:0]       snd0_dst,
    output logic [DSZ-1:0]       snd0_dat,
    output logic [RSZ-1:0]       snd0_red,

    output logic [1:0]           gnt_last,
    output logic [1:0]           o_dbg_state,
    output logic [$clog2(FSZ):0] o_dbg_count,
    output logic [1:0]           o_dbg_rr_ptr
);

    localparam int MW = 2 * ASZ + DSZ + RSZ;

    // Channel handshake (both sides, 4-phase): a sender raises req with its
    // message stable; the receiver raises ack once it has taken the message;
    // the sender drops req, then the receiver drops ack; only then may req rise again.

    logic [NUM_IN-1:0] w_req;
    logic [NUM_IN-1:0] w_cand;
    logic [NUM_IN-1:0] w_gnt_vec;
    logic [MW-1:0]     w_msg [NUM_IN];
    logic [2:0]        w_pick;
    logic [1:0]        w_win;
    logic              w_grant;
    logic [MW-1:0]     w_head;
    logic              w_full;
    logic              w_empty;
    logic              w_load;
    logic              w_snd_clr;

    logic [NUM_IN-1:0] r_ack;
    logic [1:0]        r_rr_ptr;
    logic [1:0]        r_gnt_last;
    logic              r_ready;
    logic              r_snd_req;
    logic [MW-1:0]     r_snd_msg;
    snd_state_e        r_state;
    snd_state_e        w_state_nxt;

    // Returns {found, index} of the first candidate at or after ptr, modulo 4.
    function automatic logic [2:0] rr_pick(input logic [3:0] cand, input logic [1:0] ptr);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        idx = ptr;
        for (int i = 0; i < 4; i++) begin
            if (!res[2] && cand[idx]) begin
                res = {1'b1, idx};
            end
            idx = idx + 2'd1;
        end
        return res;
    endfunction

    assign w_req    = {rcv3_req, rcv2_req, rcv1_req, rcv0_req};
    assign w_msg[0] = {rcv0_src, rcv0_dst, rcv0_dat, rcv0_red};
    assign w_msg[1] = {rcv1_src, rcv1_dst, rcv1_dat, rcv1_red};
    assign w_msg[2] = {rcv2_src, rcv2_dst, rcv2_dat, rcv2_red};
    assign w_msg[3] = {rcv3_src, rcv3_dst, rcv3_dat, rcv3_red};

    assign w_cand  = w_req & ~r_ack & cfg_en;
    assign w_pick  = rr_pick(w_cand, r_rr_ptr);
    assign w_win   = w_pick[1:0];
    // Full is judged on the pre-edge count; a same-cycle pop frees nothing yet.
    assign w_grant = w_pick[2] && !w_full;

    always_comb begin
        w_gnt_vec = '0;
        if (w_grant) begin
            w_gnt_vec[w_win] = 1'b1;
        end
    end

    ns_msg_fifo #(
        .FSZ (FSZ),
        .MW  (MW)
    ) u_fifo (
        .i_clk      (gch_clk),
        .i_rst      (gch_reset),
        .i_push     (w_grant),
        .i_push_msg (w_msg[w_win]),
        .i_pop      (w_load),
        .o_head_msg (w_head),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_count    (o_dbg_count)
    );

    // Ack release depends only on req going low, so masking or a full FIFO
    // never strands a sender mid-handshake.
    always_ff @(posedge gch_clk or posedge gch_reset) begin
        if (gch_reset) begin
            r_ready    <= 1'b0;
            r_ack      <= '0;
            r_rr_ptr   <= 2'd0;
            r_gnt_last <= 2'd0;
        end else begin
            r_ready <= 1'b1;
            r_ack   <= (r_ack & w_req) | w_gnt_vec;
            if (w_grant) begin
                r_rr_ptr   <= rr_inc(w_win);
                r_gnt_last <= w_win;
            end
        end
    end

    always_ff @(posedge gch_clk or posedge gch_reset) begin
        if (gch_reset) begin
            r_state <= SND_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_snd_clr   = 1'b0;
        case (r_state)
            SND_IDLE: begin
                if (!w_empty && !snd0_ack) begin
                    w_load      = 1'b1;
                    w_state_nxt = SND_BUSY;
                end
            end
            SND_BUSY: begin
                if (snd0_ack) begin
                    w_snd_clr   = 1'b1;
                    w_state_nxt = SND_WAIT;
                end
            end
            SND_WAIT: begin
                if (!snd0_ack) begin
                    w_state_nxt = SND_IDLE;
                end
            end
            default: begin
                w_state_nxt = SND_IDLE;
            end
        endcase
    end

    // Message regs change only on a load, so the fields hold until the next message.
    always_ff @(posedge gch_clk or posedge gch_reset) begin
        if (gch_reset) begin
            r_snd_req <= 1'b0;
            r_snd_msg <= '0;
        end else if (w_load) begin
            r_snd_req <= 1'b1;
            r_snd_msg <= w_head;
        end else if (w_snd_clr) begin
            r_snd_req <= 1'b0;
        end
    end

    assign gch_ready    = r_ready;
    assign rcv0_ack     = r_ack[0];
    assign rcv1_ack     = r_ack[1];
    assign rcv2_ack     = r_ack[2];
    assign rcv3_ack     = r_ack[3];
    assign snd0_req     = r_snd_req;
    assign {snd0_src, snd0_dst, snd0_dat, snd0_red} = r_snd_msg;
    assign gnt_last     = r_gnt_last;
    assign o_dbg_state  = r_state;
    assign o_dbg_rr_ptr = r_rr_ptr;

endmodule

// File: tb/tb_nd_rr_4to1.sv
// Bench for nd_rr_4to1: 4-phase sender tasks per input, a 4-phase receiver on
// snd0, and a scoreboard queue holding messages in their required output order.
module tb_nd_rr_4to1;

    localparam int FSZ    = 4;
    localparam int ASZ    = 8;
    localparam int DSZ    = 8;
    localparam int RSZ    = 4;
    localparam int MW     = 2 * ASZ + DSZ + RSZ;
    localparam int BUDGET = 300;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [3:0]     cfg_en;
    logic           rcv_req [4];
    logic           rcv_ack [4];
    logic [ASZ-1:0] rcv_src [4];
    logic [ASZ-1:0] rcv_dst [4];
    logic [DSZ-1:0] rcv_dat [4];
    logic [RSZ-1:0] rcv_red [4];
    logic           snd0_req;
    logic           snd0_ack;
    logic [ASZ-1:0] snd0_src;
    logic [ASZ-1:0] snd0_dst;
    logic [DSZ-1:0] snd0_dat;
    logic [RSZ-1:0] snd0_red;
    logic [1:0]     gnt_last;
    logic           gch_ready;
    logic [1:0]     dbg_state;
    logic [2:0]     dbg_count;
    logic [1:0]     dbg_rr_ptr;

    logic [MW-1:0]  exp_q[$];
    logic [MW-1:0]  msgs [4][8];
    int             n_msg [4];
    int             acks_got [4];
    int             ack_rise [4];
    logic           done [4];
    logic           rx_hold;
    int             rx_cnt;
    int             n_checks;
    int             n_errors;

    nd_rr_4to1 #(.FSZ(FSZ), .ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ)) dut (
        .gch_clk(clk), .gch_reset(rst), .gch_ready(gch_ready), .cfg_en(cfg_en),
        .rcv0_req(rcv_req[0]), .rcv0_ack(rcv_ack[0]), .rcv0_src(rcv_src[0]),
        .rcv0_dst(rcv_dst[0]), .rcv0_dat(rcv_dat[0]), .rcv0_red(rcv_red[0]),
        .rcv1_req(rcv_req[1]), .rcv1_ack(rcv_ack[1]), .rcv1_src(rcv_src[1]),
        .rcv1_dst(rcv_dst[1]), .rcv1_dat(rcv_dat[1]), .rcv1_red(rcv_red[1]),
        .rcv2_req(rcv_req[2]), .rcv2_ack(rcv_ack[2]), .rcv2_src(rcv_src[2]),
        .rcv2_dst(rcv_dst[2]), .rcv2_dat(rcv_dat[2]), .rcv2_red(rcv_red[2]),
        .rcv3_req(rcv_req[3]), .rcv3_ack(rcv_ack[3]), .rcv3_src(rcv_src[3]),
        .rcv3_dst(rcv_dst[3]), .rcv3_dat(rcv_dat[3]), .rcv3_red(rcv_red[3]),
        .snd0_req(snd0_req), .snd0_ack(snd0_ack), .snd0_src(snd0_src),
        .snd0_dst(snd0_dst), .snd0_dat(snd0_dat), .snd0_red(snd0_red),
        .gnt_last(gnt_last), .o_dbg_state(dbg_state), .o_dbg_count(dbg_count),
        .o_dbg_rr_ptr(dbg_rr_ptr)
    );

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    task automatic gen_msgs(input int k, input int n);
        n_msg[k] = n;
        done[k]  = 1'b0;
        for (int j = 0; j < n; j++) begin
            msgs[k][j] = {ASZ'($urandom_range(0, 255)), ASZ'($urandom_range(0, 255)),
                          DSZ'($urandom_range(0, 255)), RSZ'($urandom_range(0, 15))};
        end
    endtask

    task automatic send_seq(input int k);
        int b;
        for (int j = 0; j < n_msg[k]; j++) begin
            b = 0;
            while (rcv_ack[k] && b < BUDGET) begin
                tick();
                b++;
            end
            {rcv_src[k], rcv_dst[k], rcv_dat[k], rcv_red[k]} = msgs[k][j];
            rcv_req[k] = 1'b1;
            b = 0;
            do begin
                tick();
                b++;
            end while (!rcv_ack[k] && b < BUDGET);
            if (!rcv_ack[k]) begin
                chk($sformatf("ack_timeout_in%0d", k), 32'(rcv_ack[k]), 32'd1);
                rcv_req[k] = 1'b0;
                break;
            end
            acks_got[k]++;
            rcv_req[k] = 1'b0;
        end
        done[k] = 1'b1;
    endtask

    task automatic wait_done(input string tag);
        int b;
        b = 0;
        while (!(done[0] && done[1] && done[2] && done[3]) && b < BUDGET) begin
            tick();
            b++;
        end
        chk(tag, 32'({done[3], done[2], done[1], done[0]}), 32'hF);
    endtask

    task automatic wait_drain(input string tag);
        int b;
        b = 0;
        while ((exp_q.size() != 0 || snd0_req || snd0_ack) && b < BUDGET) begin
            tick();
            b++;
        end
        chk(tag, 32'(exp_q.size()), 32'd0);
    endtask

    // ---------------- receiver + scoreboard ----------------
    task automatic rx_loop();
        logic [MW-1:0] got;
        logic [MW-1:0] want;
        logic          prev [4];
        for (int k = 0; k < 4; k++) prev[k] = 1'b0;
        forever begin
            tick();
            for (int k = 0; k < 4; k++) begin
                if (rcv_ack[k] && !prev[k]) ack_rise[k]++;
                prev[k] = rcv_ack[k];
            end
            if (snd0_ack && !snd0_req) begin
                snd0_ack = 1'b0;
            end else if (snd0_req && !snd0_ack && !rx_hold) begin
                got = {snd0_src, snd0_dst, snd0_dat, snd0_red};
                if (exp_q.size() == 0) begin
                    chk("sb_extra_msg", 32'(exp_q.size()), 32'd1);
                end else begin
                    want = exp_q.pop_front();
                    chk("sb_msg", 32'(got), 32'(want));
                end
                rx_cnt++;
                snd0_ack = 1'b1;
            end
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int base1;
        int base3;
        int rx_before;
        n_checks = 0;
        n_errors = 0;
        rx_cnt   = 0;
        rx_hold  = 1'b0;
        snd0_ack = 1'b0;
        cfg_en   = 4'hF;
        rst      = 1'b1;
        for (int k = 0; k < 4; k++) begin
            rcv_req[k] = 1'b0; rcv_src[k] = '0; rcv_dst[k] = '0;
            rcv_dat[k] = '0;   rcv_red[k] = '0; acks_got[k] = 0;
            ack_rise[k] = 0;   n_msg[k] = 0;    done[k] = 1'b1;
        end
        fork
            rx_loop();
        join_none

        // Reset state.
        repeat (2) tick();
        chk("rst_ready", 32'(gch_ready), 32'd0);
        chk("rst_snd_req", 32'(snd0_req), 32'd0);
        chk("rst_gnt_last", 32'(gnt_last), 32'd0);
        chk("rst_count", 32'(dbg_count), 32'd0);
        chk("rst_state", 32'(dbg_state), 32'd0);
        chk("rst_rr_ptr", 32'(dbg_rr_ptr), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("ready_pre_edge", 32'(gch_ready), 32'd0);
        tick();
        chk("ready_post_edge", 32'(gch_ready), 32'd1);

        // Single input on rcv2.
        rcv_src[2] = 8'd3; rcv_dst[2] = 8'd5; rcv_dat[2] = 8'hA5;
        rcv_red[2] = RSZ'($urandom_range(0, 15));
        exp_q.push_back({8'd3, 8'd5, 8'hA5, rcv_red[2]});
        rcv_req[2] = 1'b1;
        tick();
        chk("t1_ack_rise", 32'(rcv_ack[2]), 32'd1);
        chk("t1_gnt_last", 32'(gnt_last), 32'd2);
        chk("t1_snd_req_early", 32'(snd0_req), 32'd0);
        rcv_req[2] = 1'b0;
        tick();
        chk("t1_snd_req", 32'(snd0_req), 32'd1);
        chk("t1_src", 32'(snd0_src), 32'd3);
        chk("t1_dst", 32'(snd0_dst), 32'd5);
        chk("t1_dat", 32'(snd0_dat), 32'hA5);
        chk("t1_ack_fall", 32'(rcv_ack[2]), 32'd0);
        wait_drain("t1_drain");
        chk("t1_rr_ptr", 32'(dbg_rr_ptr), 32'd3);

        // All four inputs requesting continuously: order 0,1,2,3,... from reset.
        do_reset();
        for (int k = 0; k < 4; k++) gen_msgs(k, 3);
        for (int j = 0; j < 3; j++)
            for (int k = 0; k < 4; k++) exp_q.push_back(msgs[k][j]);
        fork
            send_seq(0); send_seq(1); send_seq(2); send_seq(3);
        join_none
        wait_done("t2_done");
        wait_drain("t2_drain");
        chk("t2_gnt_last", 32'(gnt_last), 32'd3);

        // Back-pressure: snd0_ack held low, 6 messages offered on input 0.
        do_reset();
        rx_hold = 1'b1;
        gen_msgs(0, 6);
        acks_got[0] = 0;
        for (int j = 0; j < 6; j++) exp_q.push_back(msgs[0][j]);
        fork
            send_seq(0);
        join_none
        repeat (40) tick();
        chk("bp_acked", 32'(acks_got[0]), 32'd5);
        chk("bp_count", 32'(dbg_count), 32'd4);
        chk("bp_req6_held", 32'(rcv_req[0]), 32'd1);
        chk("bp_ack6_low", 32'(rcv_ack[0]), 32'd0);
        chk("bp_snd_req", 32'(snd0_req), 32'd1);
        chk("bp_snd_msg", 32'({snd0_src, snd0_dst, snd0_dat, snd0_red}), 32'(msgs[0][0]));
        rx_hold = 1'b0;
        wait_done("bp_done");
        wait_drain("bp_drain");
        chk("bp_acked_all", 32'(acks_got[0]), 32'd6);

        // Mask 0101: 0,2,0,2; then 1111 admits 3 ahead of 1.
        do_reset();
        cfg_en = 4'b0101;
        gen_msgs(0, 2); gen_msgs(1, 1); gen_msgs(2, 2); gen_msgs(3, 1);
        exp_q.push_back(msgs[0][0]); exp_q.push_back(msgs[2][0]);
        exp_q.push_back(msgs[0][1]); exp_q.push_back(msgs[2][1]);
        exp_q.push_back(msgs[3][0]); exp_q.push_back(msgs[1][0]);
        base1 = ack_rise[1];
        base3 = ack_rise[3];
        fork
            send_seq(0); send_seq(1); send_seq(2); send_seq(3);
        join_none
        begin
            int b;
            b = 0;
            while (!(done[0] && done[2]) && b < BUDGET) begin
                tick();
                b++;
            end
        end
        repeat (4) tick();
        chk("mask_done02", 32'({done[2], done[0]}), 32'h3);
        chk("mask_ack1_none", 32'(ack_rise[1] - base1), 32'd0);
        chk("mask_ack3_none", 32'(ack_rise[3] - base3), 32'd0);
        chk("mask_gnt_last", 32'(gnt_last), 32'd2);
        cfg_en = 4'b1111;
        wait_done("mask_done_all");
        wait_drain("mask_drain");
        chk("mask_gnt_last_end", 32'(gnt_last), 32'd1);

        // Async reset with 3 queued messages and snd0_req high.
        do_reset();
        rx_hold = 1'b1;
        gen_msgs(0, 4);
        fork
            send_seq(0);
        join_none
        wait_done("ar_done");
        chk("ar_pre_count", 32'(dbg_count), 32'd3);
        chk("ar_pre_snd_req", 32'(snd0_req), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("ar_snd_req", 32'(snd0_req), 32'd0);
        chk("ar_ready", 32'(gch_ready), 32'd0);
        chk("ar_gnt_last", 32'(gnt_last), 32'd0);
        chk("ar_snd_msg", 32'({snd0_src, snd0_dst, snd0_dat, snd0_red}), 32'd0);
        chk("ar_acks", 32'({rcv_ack[3], rcv_ack[2], rcv_ack[1], rcv_ack[0]}), 32'd0);
        chk("ar_count", 32'(dbg_count), 32'd0);
        chk("ar_state", 32'(dbg_state), 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("ar_ready_pre_edge", 32'(gch_ready), 32'd0);
        tick();
        chk("ar_ready_post_edge", 32'(gch_ready), 32'd1);
        rx_before = rx_cnt;
        rx_hold = 1'b0;
        repeat (20) tick();
        chk("ar_no_stale_req", 32'(snd0_req), 32'd0);
        chk("ar_no_stale_rx", 32'(rx_cnt - rx_before), 32'd0);
        gen_msgs(1, 1);
        exp_q.push_back(msgs[1][0]);
        fork
            send_seq(1);
        join_none
        wait_done("ar_after_done");
        wait_drain("ar_after_drain");

        // ---------------- final report ----------------
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
